// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR writeback block.
// - gpr_state_e : INIT (sequential clear of the register file) / RUN
// - GPR_REG_NUM : default register count
// - GPR_ID_W    : register-ID width for the default register count
package gpr_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } gpr_state_e;

  localparam int unsigned GPR_REG_NUM = 32;
  localparam int unsigned GPR_ID_W    = $clog2(GPR_REG_NUM);

endpackage

// File: rtl/gpr_scb.sv
// GPR scoreboard: one busy bit per register.
// Ports:
//   clk, rst_n      : clock / synchronous active-low reset (clears all bits)
//   set_en, set_id  : mark a register busy (reservation at issue)
//   clr_en, clr_id  : mark a register idle (committed writeback)
//   rs1_id, rs2_id, rsv_id    : lookup addresses
//   busy_rs1, busy_rs2, busy_rsv : busy bit of each lookup address
// Register 0 is never marked busy. A set and a clear of the same ID in one
// cycle leaves the bit set.
module gpr_scb #(
  parameter int unsigned REG_NUM = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       set_en,
  input  logic [$clog2(REG_NUM)-1:0] set_id,
  input  logic                       clr_en,
  input  logic [$clog2(REG_NUM)-1:0] clr_id,
  input  logic [$clog2(REG_NUM)-1:0] rs1_id,
  input  logic [$clog2(REG_NUM)-1:0] rs2_id,
  input  logic [$clog2(REG_NUM)-1:0] rsv_id,
  output logic                       busy_rs1,
  output logic                       busy_rs2,
  output logic                       busy_rsv
);

  logic [REG_NUM-1:0] busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_id] <= 1'b0;
      // Later assignment takes precedence: a reservation beats a clear.
      if (set_en && (set_id != '0)) busy[set_id] <= 1'b1;
    end
  end

  assign busy_rs1 = busy[rs1_id];
  assign busy_rs2 = busy[rs2_id];
  assign busy_rsv = busy[rsv_id];

endmodule

// File: rtl/gpr_wb.sv
// General-purpose register file with writeback handshake and hazard tracking.
// After reset the file is cleared one register per cycle (INIT), then the
// block accepts writebacks (RUN).
// Ports:
//   i_sys_clk, i_sys_rst_n  : clock / synchronous active-low reset
//   i_wbu_valid, o_gpr_ready: writeback handshake
//   i_wbu_gpr_wr_en/id/data : write qualifier, destination, data
//   i_idu_rsv_en/id         : reserve a destination at issue (marks busy)
//   i_idu_rs1_id/rs2_id     : combinational read addresses
//   o_gpr_rs1_data/rs2_data : read data (0 for ID 0 and outside RUN)
//   o_gpr_stall             : hazard on rs1, rs2 or the reserved ID (1 in INIT)
// Configuration macro GPR_BYPASS_EN: forward a same-cycle accepted write to
// matching reads and drop that ID from the stall term.
module gpr_wb
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_NUM    = GPR_REG_NUM
) (
  input  logic                       i_sys_clk,
  input  logic                       i_sys_rst_n,
  input  logic                       i_wbu_valid,
  output logic                       o_gpr_ready,
  input  logic                       i_wbu_gpr_wr_en,
  input  logic [$clog2(REG_NUM)-1:0] i_wbu_gpr_wr_id,
  input  logic [DATA_WIDTH-1:0]      i_wbu_gpr_wr_data,
  input  logic                       i_idu_rsv_en,
  input  logic [$clog2(REG_NUM)-1:0] i_idu_rsv_id,
  input  logic [$clog2(REG_NUM)-1:0] i_idu_rs1_id,
  input  logic [$clog2(REG_NUM)-1:0] i_idu_rs2_id,
  output logic [DATA_WIDTH-1:0]      o_gpr_rs1_data,
  output logic [DATA_WIDTH-1:0]      o_gpr_rs2_data,
  output logic                       o_gpr_stall
);

  localparam int unsigned ID_W = $clog2(REG_NUM);

  gpr_state_e            state, state_nxt;
  logic [ID_W-1:0]       clr_cnt;
  logic [DATA_WIDTH-1:0] regs [REG_NUM];
  logic                  run;
  logic                  wr_fire;
  logic                  busy_rs1, busy_rs2, busy_rsv;
  logic                  hit_rs1, hit_rs2, hit_rsv;

  assign run         = (state == RUN);
  assign o_gpr_ready = run;
  assign wr_fire     = i_wbu_valid & o_gpr_ready & i_wbu_gpr_wr_en
                       & (i_wbu_gpr_wr_id != '0);

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) clr_cnt <= clr_cnt + ID_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (clr_cnt == ID_W'(REG_NUM - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst_n) begin
      if (state == INIT)  regs[clr_cnt]         <= '0;
      else if (wr_fire)   regs[i_wbu_gpr_wr_id] <= i_wbu_gpr_wr_data;
    end
  end

  gpr_scb #(
    .REG_NUM (REG_NUM)
  ) u_scb (
    .clk      (i_sys_clk),
    .rst_n    (i_sys_rst_n),
    .set_en   (i_idu_rsv_en & run),
    .set_id   (i_idu_rsv_id),
    .clr_en   (wr_fire),
    .clr_id   (i_wbu_gpr_wr_id),
    .rs1_id   (i_idu_rs1_id),
    .rs2_id   (i_idu_rs2_id),
    .rsv_id   (i_idu_rsv_id),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .busy_rsv (busy_rsv)
  );

`ifdef GPR_BYPASS_EN
  assign hit_rs1 = wr_fire && (i_idu_rs1_id == i_wbu_gpr_wr_id);
  assign hit_rs2 = wr_fire && (i_idu_rs2_id == i_wbu_gpr_wr_id);
  assign hit_rsv = wr_fire && (i_idu_rsv_id == i_wbu_gpr_wr_id);
`else
  assign hit_rs1 = 1'b0;
  assign hit_rs2 = 1'b0;
  assign hit_rsv = 1'b0;
`endif

  always_comb begin
    o_gpr_rs1_data = '0;
    o_gpr_rs2_data = '0;
    if (run && (i_idu_rs1_id != '0))
      o_gpr_rs1_data = hit_rs1 ? i_wbu_gpr_wr_data : regs[i_idu_rs1_id];
    if (run && (i_idu_rs2_id != '0))
      o_gpr_rs2_data = hit_rs2 ? i_wbu_gpr_wr_data : regs[i_idu_rs2_id];
  end

  always_comb begin
    o_gpr_stall = 1'b1;
    if (run)
      o_gpr_stall = (busy_rs1 & ~hit_rs1) | (busy_rs2 & ~hit_rs2)
                  | (i_idu_rsv_en & busy_rsv & ~hit_rsv);
  end

endmodule

// File: tb/tb_gpr_wb.sv
// Directed testbench for gpr_wb (default 32 x 32-bit configuration).
module tb_gpr_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic        wr_en;
  logic [4:0]  wr_id;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_id;
  logic [4:0]  rs1_id, rs2_id;
  logic [31:0] rs1_data, rs2_data;
  logic        stall;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc;

  always #5 clk = ~clk;

  gpr_wb #(
    .DATA_WIDTH (32),
    .REG_NUM    (32)
  ) dut (
    .i_sys_clk         (clk),
    .i_sys_rst_n       (rst_n),
    .i_wbu_valid       (valid),
    .o_gpr_ready       (ready),
    .i_wbu_gpr_wr_en   (wr_en),
    .i_wbu_gpr_wr_id   (wr_id),
    .i_wbu_gpr_wr_data (wr_data),
    .i_idu_rsv_en      (rsv_en),
    .i_idu_rsv_id      (rsv_id),
    .i_idu_rs1_id      (rs1_id),
    .i_idu_rs2_id      (rs2_id),
    .o_gpr_rs1_data    (rs1_data),
    .o_gpr_rs2_data    (rs2_data),
    .o_gpr_stall       (stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready rises, bounded.
  task automatic wait_ready(output int unsigned n);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic idle();
    valid = 0; wr_en = 0; wr_id = 0; wr_data = 0;
    rsv_en = 0; rsv_id = 0;
  endtask

  initial begin
    idle();
    rs1_id = 0; rs2_id = 0;
    rst_n = 0;
    step(); step(); step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_stall", 32'(stall), 32'd1);

    // Reset release: ready low for exactly 32 cycles.
    rst_n = 1;
    #1;
    check("init_ready0", 32'(ready), 32'd0);
    wait_ready(cyc);
    check("init_cycles", cyc, 32'd32);
    check("run_ready", 32'(ready), 32'd1);
    check("run_stall_idle", 32'(stall), 32'd0);

    // Write id 1 = 8000_0000.
    valid = 1; wr_en = 1; wr_id = 1; wr_data = 32'h8000_0000; rs1_id = 1;
    #1;
`ifdef GPR_BYPASS_EN
    check("wr1_same_cycle", rs1_data, 32'h8000_0000);
`else
    check("wr1_same_cycle", rs1_data, 32'h0);
`endif
    step(); idle();
    #1;
    check("wr1_read", rs1_data, 32'h8000_0000);

    // Handshake without write enable leaves register 2 unchanged.
    valid = 1; wr_en = 0; wr_id = 2; wr_data = 32'hA5A5_A5A5; rs2_id = 2;
    step(); idle();
    #1;
    check("wren0_read", rs2_data, 32'h0);
    valid = 1; wr_en = 1; wr_id = 2; wr_data = 32'h1234_5678;
    step(); idle();
    #1;
    check("wr2_read", rs2_data, 32'h1234_5678);
    check("wr2_rs1_kept", rs1_data, 32'h8000_0000);

    // ID 0: writes ignored, reservation ignored.
    valid = 1; wr_en = 1; wr_id = 0; wr_data = 32'h2; rs1_id = 0;
    step(); idle();
    #1;
    check("wr0_read", rs1_data, 32'h0);
    rsv_en = 1; rsv_id = 0; rs2_id = 0;
    #1;
    check("rsv0_stall_now", 32'(stall), 32'd0);
    step(); idle();
    #1;
    check("rsv0_stall_after", 32'(stall), 32'd0);

    // Reserve id 3, then clear it with a write.
    rsv_en = 1; rsv_id = 3;
    step(); idle();
    rs2_id = 3;
    #1;
    check("rsv3_stall", 32'(stall), 32'd1);
    valid = 1; wr_en = 1; wr_id = 3; wr_data = 32'h1;
    #1;
`ifdef GPR_BYPASS_EN
    check("wr3_stall_same", 32'(stall), 32'd0);
    check("wr3_data_same", rs2_data, 32'h1);
`else
    check("wr3_stall_same", 32'(stall), 32'd1);
    check("wr3_data_same", rs2_data, 32'h0);
`endif
    step(); idle();
    #1;
    check("wr3_stall_after", 32'(stall), 32'd0);
    check("wr3_data_after", rs2_data, 32'h1);

    // Simultaneous reserve and write on id 5: reservation wins.
    rs2_id = 0;
    rsv_en = 1; rsv_id = 5; valid = 1; wr_en = 1; wr_id = 5; wr_data = 32'h7;
    step(); idle();
    rs1_id = 5;
    #1;
    check("rsvwr5_stall", 32'(stall), 32'd1);
    check("rsvwr5_data", rs1_data, 32'h7);
    // Reserved-ID term alone.
    rs1_id = 0; rsv_en = 1; rsv_id = 5;
    #1;
    check("rsv_busy_term", 32'(stall), 32'd1);
    rsv_en = 0;
    #1;
    check("rsv_busy_term_off", 32'(stall), 32'd0);
    valid = 1; wr_en = 1; wr_id = 5; wr_data = 32'h9;
    step(); idle();
    rs1_id = 5;
    #1;
    check("wr5_stall_clear", 32'(stall), 32'd0);
    check("wr5_data", rs1_data, 32'h9);

    // Leave id 7 busy, then reset mid-INIT at count 10.
    rsv_en = 1; rsv_id = 7;
    step(); idle();
    rst_n = 0;
    rs1_id = 1;
    step();
    check("rst2_stall", 32'(stall), 32'd1);
    check("rst2_data", rs1_data, 32'h0);
    rst_n = 1;
    repeat (10) step();
    check("mid_init_ready", 32'(ready), 32'd0);
    rst_n = 0;
    step();
    rst_n = 1;
    rsv_en = 1; rsv_id = 4;   // must be ignored during INIT
    #1;
    wait_ready(cyc);
    idle();
    check("reinit_cycles", cyc, 32'd32);
    rs1_id = 7; rs2_id = 4;
    #1;
    check("reinit_busy_clear", 32'(stall), 32'd0);
    rs1_id = 1;
    #1;
    check("reinit_reg_clear", rs1_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
